// File: rtl/lpc_sink_ram_pkg.sv
// lpc_sink_ram_pkg: shared types, constants and helpers for the LPC sink buffer RAM
package lpc_sink_ram_pkg;

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    localparam int LAT_MAX  = 2;
    localparam int MAX_BYTE = 32;

    function automatic int be_width(input int dw, input int bs);
        return dw / bs;
    endfunction

    function automatic logic even_parity(input logic [MAX_BYTE-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/lpc_sink_ram_core.sv
// lpc_sink_ram_core: true-dual-port array, byte-lane writes, registered old-data reads
module lpc_sink_ram_core #(
    parameter int NB = 2,
    parameter int LW = 8,
    parameter int AW = 11
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AW-1:0]   a_addr,
    input  logic [NB-1:0]   a_we,
    input  logic [NB*LW-1:0] a_wdata,
    input  logic            a_re,
    output logic [NB*LW-1:0] a_rdata,
    input  logic [AW-1:0]   b_addr,
    input  logic [NB-1:0]   b_we,
    input  logic [NB*LW-1:0] b_wdata,
    input  logic            b_re,
    output logic [NB*LW-1:0] b_rdata
);

    logic [NB*LW-1:0] mem [2**AW];

    // lane-wise writes from both ports; same-address double writes are arbitrated upstream
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (a_we[i]) mem[a_addr][i*LW +: LW] <= a_wdata[i*LW +: LW];
            if (b_we[i]) mem[b_addr][i*LW +: LW] <= b_wdata[i*LW +: LW];
        end
    end

    // registered reads sample the array before this cycle's writes land, giving old data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            if (a_re) a_rdata <= mem[a_addr];
            if (b_re) b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/lpc_dual_port_buffer_ram.sv
// lpc_dual_port_buffer_ram: two Avalon-MM slaves over a clearable buffer RAM (option: LPC_SINK_RAM_PARITY_EN)
module lpc_dual_port_buffer_ram
    import lpc_sink_ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int BYTE_SIZE      = 8,
    parameter int ADDR_WIDTH     = 11,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             clear_req,
    output logic                             clear_busy,
    input  logic [ADDR_WIDTH-1:0]            s1_address,
    input  logic                             s1_chipselect,
    input  logic                             s1_read,
    input  logic                             s1_write,
    input  logic [DATA_WIDTH/BYTE_SIZE-1:0]  s1_byteenable,
    input  logic [DATA_WIDTH-1:0]            s1_writedata,
    output logic [DATA_WIDTH-1:0]            s1_readdata,
    output logic                             s1_readdatavalid,
    output logic                             s1_waitrequest,
    input  logic [ADDR_WIDTH-1:0]            s2_address,
    input  logic                             s2_chipselect,
    input  logic                             s2_read,
    input  logic                             s2_write,
    input  logic [DATA_WIDTH/BYTE_SIZE-1:0]  s2_byteenable,
    input  logic [DATA_WIDTH-1:0]            s2_writedata,
    output logic [DATA_WIDTH-1:0]            s2_readdata,
    output logic                             s2_readdatavalid,
    output logic                             s2_waitrequest
`ifdef LPC_SINK_RAM_PARITY_EN
    ,
    output logic                             s1_parity_err,
    output logic                             s2_parity_err
`endif
);

    localparam int NB = be_width(DATA_WIDTH, BYTE_SIZE);
`ifdef LPC_SINK_RAM_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int LW = BYTE_SIZE + PB;
    localparam int W  = NB * LW;

    state_t                          state, state_n;
    logic [ADDR_WIDTH-1:0]           ptr, ptr_n;
    logic                            live, clr, coll;
    logic [1:0]                      acc, rd_acc, wr_in;
    logic [1:0][NB-1:0]              we, be_in;
    logic [1:0][DATA_WIDTH-1:0]      wdat_in, dat, dat_q;
    logic [1:0][W-1:0]               wword, rword;
    logic [1:0][LAT_MAX-1:0]         vld;

    // live stays low through reset and its first clock so waitrequest reads 1 and clear_busy 0 in reset
    assign clr        = live && state == ST_CLEAR;
    assign clear_busy = clr;
    assign coll       = live && !clr && s1_chipselect && s1_write && s2_chipselect && s2_write &&
                        s1_address == s2_address;

    assign s1_waitrequest = ~live | clr;
    assign s2_waitrequest = ~live | clr | coll;

    assign acc[0]  = s1_chipselect & (s1_read | s1_write) & ~s1_waitrequest;
    assign acc[1]  = s2_chipselect & (s2_read | s2_write) & ~s2_waitrequest;
    assign wr_in   = {s2_write, s1_write};
    assign rd_acc  = acc & ~wr_in;
    assign be_in   = {s2_byteenable, s1_byteenable};
    assign wdat_in = {s2_writedata, s1_writedata};

    assign we[0] = clr ? {NB{1'b1}} : (acc[0] & wr_in[0] ? be_in[0] : '0);
    assign we[1] = acc[1] & wr_in[1] ? be_in[1] : '0;

    // state and clear pointer; reset always restarts the clear from word 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAR_ON_RESET != 0 ? ST_CLEAR : ST_IDLE;
            ptr   <= '0;
            live  <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            live  <= 1'b1;
        end
    end

    // clear sweeps every word once, then returns to IDLE; clear_req is honoured only in IDLE
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        if (clr) begin
            ptr_n = ptr + 1'b1;
            if (&ptr) state_n = ST_IDLE;
        end else if (live && clear_req) begin
            state_n = ST_CLEAR;
            ptr_n   = '0;
        end
    end

    // pack write data into lanes (plus parity bit when enabled); the clear engine forces zeros on port 1
    always_comb begin
        wword = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < NB; i++) begin
                wword[p][i*LW +: BYTE_SIZE] = wdat_in[p][i*BYTE_SIZE +: BYTE_SIZE];
`ifdef LPC_SINK_RAM_PARITY_EN
                wword[p][i*LW + BYTE_SIZE] = even_parity(MAX_BYTE'(wdat_in[p][i*BYTE_SIZE +: BYTE_SIZE]));
`endif
            end
        end
        if (clr) wword[0] = '0;
    end

    lpc_sink_ram_core #(.NB(NB), .LW(LW), .AW(ADDR_WIDTH)) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .a_addr  (clr ? ptr : s1_address),
        .a_we    (we[0]),
        .a_wdata (wword[0]),
        .a_re    (rd_acc[0]),
        .a_rdata (rword[0]),
        .b_addr  (s2_address),
        .b_we    (we[1]),
        .b_wdata (wword[1]),
        .b_re    (rd_acc[1]),
        .b_rdata (rword[1])
    );

`ifdef LPC_SINK_RAM_PARITY_EN
    logic [1:0] perr, perr_q;
`endif

    // unpack read words and recompute lane parity
    always_comb begin
        dat = '0;
`ifdef LPC_SINK_RAM_PARITY_EN
        perr = '0;
`endif
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < NB; i++) begin
                dat[p][i*BYTE_SIZE +: BYTE_SIZE] = rword[p][i*LW +: BYTE_SIZE];
`ifdef LPC_SINK_RAM_PARITY_EN
                perr[p] = perr[p] | (even_parity(MAX_BYTE'(rword[p][i*LW +: BYTE_SIZE])) != rword[p][i*LW + BYTE_SIZE]);
`endif
            end
        end
    end

    // valid pipes and the extra output stage used when READ_LATENCY is 2
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld   <= '0;
            dat_q <= '0;
`ifdef LPC_SINK_RAM_PARITY_EN
            perr_q <= '0;
`endif
        end else begin
            for (int p = 0; p < 2; p++) begin
                vld[p] <= {vld[p][0], rd_acc[p]};
                if (vld[p][0]) dat_q[p] <= dat[p];
`ifdef LPC_SINK_RAM_PARITY_EN
                if (vld[p][0]) perr_q[p] <= perr[p];
`endif
            end
        end
    end

    assign s1_readdata      = READ_LATENCY == 2 ? dat_q[0] : dat[0];
    assign s2_readdata      = READ_LATENCY == 2 ? dat_q[1] : dat[1];
    assign s1_readdatavalid = vld[0][READ_LATENCY-1];
    assign s2_readdatavalid = vld[1][READ_LATENCY-1];
`ifdef LPC_SINK_RAM_PARITY_EN
    assign s1_parity_err = vld[0][READ_LATENCY-1] & (READ_LATENCY == 2 ? perr_q[0] : perr[0]);
    assign s2_parity_err = vld[1][READ_LATENCY-1] & (READ_LATENCY == 2 ? perr_q[1] : perr[1]);
`endif

endmodule

// File: tb/tb_lpc_dual_port_buffer_ram.sv
// tb_lpc_dual_port_buffer_ram: table vectors, corner sequences and random traffic against a word-array model
module tb_lpc_dual_port_buffer_ram;

    localparam int AW    = 6;
    localparam int LAT   = 2;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clear_req = 1'b0;
    logic clear_busy;
    logic [1:0] cs, rd, wr, rv, wt, pe;
    logic [1:0][AW-1:0] addr;
    logic [1:0][1:0] be;
    logic [1:0][15:0] wd, rdat;

    lpc_dual_port_buffer_ram #(
        .DATA_WIDTH(16), .BYTE_SIZE(8), .ADDR_WIDTH(AW), .READ_LATENCY(LAT), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .clear_busy(clear_busy),
        .s1_address(addr[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
        .s1_byteenable(be[0]), .s1_writedata(wd[0]), .s1_readdata(rdat[0]),
        .s1_readdatavalid(rv[0]), .s1_waitrequest(wt[0]),
        .s2_address(addr[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
        .s2_byteenable(be[1]), .s2_writedata(wd[1]), .s2_readdata(rdat[1]),
        .s2_readdatavalid(rv[1]), .s2_waitrequest(wt[1])
`ifdef LPC_SINK_RAM_PARITY_EN
        , .s1_parity_err(pe[0]), .s2_parity_err(pe[1])
`endif
    );
`ifndef LPC_SINK_RAM_PARITY_EN
    assign pe = '0;
`endif

    always #5 clk = ~clk;

    logic [15:0] mem_m [DEPTH];
    logic        ev [2][8];
    logic [15:0] ed [2][8];
    logic [15:0] last [2];
    logic        st2 = 1'b0;
    int cyc = 0, nvec = 0, nerr = 0;

    typedef struct {
        int          p;
        logic [AW-1:0] a;
        logic [15:0] init;
        logic [15:0] wdat;
        logic [1:0]  b;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic idle();
        cs = '0; rd = '0; wr = '0; be = '0; wd = '0; addr = '0;
    endtask

    task automatic flush_model();
        for (int p = 0; p < 2; p++) begin
            last[p] = '0;
            for (int k = 0; k < 8; k++) ev[p][k] = 1'b0;
        end
    endtask

    // one IDLE-state clock: check stalls, update the model, check read outputs
    task automatic tick();
        logic coll, acc;
        int s;
        @(negedge clk);
        coll = cs[0] & wr[0] & cs[1] & wr[1] & (addr[0] == addr[1]);
        chk("s1_waitrequest", wt[0], 1'b0);
        chk("s2_waitrequest", wt[1], coll);
        st2 = coll;
        for (int p = 0; p < 2; p++) begin
            acc = cs[p] & (rd[p] | wr[p]) & ~(p == 1 && coll);
            if (acc && !wr[p]) begin
                ev[p][(cyc + LAT) % 8] = 1'b1;
                ed[p][(cyc + LAT) % 8] = mem_m[addr[p]];
            end
        end
        for (int p = 0; p < 2; p++) begin
            acc = cs[p] & wr[p] & ~(p == 1 && coll);
            for (int i = 0; i < 2; i++)
                if (acc && be[p][i]) mem_m[addr[p]][8*i +: 8] = wd[p][8*i +: 8];
        end
        @(posedge clk);
        cyc++;
        #1;
        s = cyc % 8;
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("s%0d_readdatavalid", p + 1), rv[p], ev[p][s]);
            if (ev[p][s]) last[p] = ed[p][s];
            chk($sformatf("s%0d_readdata", p + 1), rdat[p], last[p]);
            ev[p][s] = 1'b0;
        end
    endtask

    task automatic wr_word(input int p, input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] b);
        idle();
        cs[p] = 1'b1; wr[p] = 1'b1; addr[p] = a; wd[p] = d; be[p] = b;
        tick();
        idle();
    endtask

    task automatic rd_word(input int p, input logic [AW-1:0] a, output logic [15:0] d, output int lat,
                           output logic perr);
        idle();
        cs[p] = 1'b1; rd[p] = 1'b1; addr[p] = a;
        tick();
        idle();
        lat = 1;
        while (!rv[p] && lat < 8) begin
            tick();
            lat++;
        end
        d = rdat[p];
        perr = pe[p];
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        clear_req = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_readdata", rdat, 32'h0);
        chk("rst_readdatavalid", rv, 2'b00);
        chk("rst_clear_busy", clear_busy, 1'b0);
        chk("rst_waitrequest", wt, 2'b11);
        chk("rst_parity_err", pe, 2'b00);
        flush_model();
        reset_n = 1'b1;
    endtask

    // count clear cycles (bounded), requiring both ports stalled throughout
    task automatic wait_clear(output int n);
        n = 0;
        for (int k = 0; k < 4 * DEPTH; k++) begin
            @(negedge clk);
            if (clear_busy) begin
                n++;
                chk("clear_waitrequest", wt, 2'b11);
            end else if (n > 0) begin
                break;
            end
        end
        idle();
        for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        logic perr;
        int lat, n;
        idle();
        flush_model();
        tbl[0] = '{0, 6'd5,  16'h1234, 16'hBEEF, 2'b01, 16'h12EF};
        tbl[1] = '{1, 6'd6,  16'h1234, 16'hBEEF, 2'b10, 16'hBE34};
        tbl[2] = '{0, 6'd7,  16'h1234, 16'hBEEF, 2'b00, 16'h1234};
        tbl[3] = '{1, 6'd8,  16'h1234, 16'hBEEF, 2'b11, 16'hBEEF};
        tbl[4] = '{0, 6'd9,  16'hFFFF, 16'h0000, 2'b10, 16'h00FF};
        tbl[5] = '{1, 6'd10, 16'h0000, 16'hA55A, 2'b01, 16'h005A};

        do_reset();
        wait_clear(n);
        chk("clear_cycles_after_reset", n, DEPTH);
        for (int a = 0; a < DEPTH; a++) begin
            rd_word(a % 2, a[AW-1:0], d, lat, perr);
            chk("cleared_word", d, 16'h0);
        end

        foreach (tbl[k]) begin
            wr_word(0, tbl[k].a, tbl[k].init, 2'b11);
            wr_word(tbl[k].p, tbl[k].a, tbl[k].wdat, tbl[k].b);
            rd_word(1 - tbl[k].p, tbl[k].a, d, lat, perr);
            chk($sformatf("byteenable_vec%0d", k), d, tbl[k].exp);
            chk("read_latency", lat, LAT);
        end

        idle();
        cs = 2'b11; wr = 2'b11; addr[0] = 6'h10; addr[1] = 6'h10;
        wd[0] = 16'hAAAA; wd[1] = 16'h5555; be[0] = 2'b11; be[1] = 2'b11;
        #4;
        chk("collision_stall", wt[1], 1'b1);
        tick();
        cs[0] = 1'b0; wr[0] = 1'b0;
        #4;
        chk("collision_retry_go", wt[1], 1'b0);
        tick();
        rd_word(0, 6'h10, d, lat, perr);
        chk("collision_final", d, 16'h5555);

        idle();
        cs = 2'b11; rd[0] = 1'b1; addr[0] = 6'h20;
        wr[1] = 1'b1; addr[1] = 6'h20; wd[1] = 16'h0F0F; be[1] = 2'b11;
        tick();
        idle();
        lat = 1;
        while (!rv[0] && lat < 8) begin
            tick();
            lat++;
        end
        chk("rdw_old_data", rdat[0], 16'h0000);
        rd_word(0, 6'h20, d, lat, perr);
        chk("rdw_new_data", d, 16'h0F0F);

        idle();
        for (int k = 0; k < 400; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (p == 0 || !st2) begin
                    cs[p] = $urandom_range(0, 3) != 0;
                    rd[p] = $urandom_range(0, 1) != 0;
                    wr[p] = $urandom_range(0, 1) != 0;
                    addr[p] = AW'($urandom_range(0, 7));
                    be[p] = 2'($urandom);
                    wd[p] = 16'($urandom);
                end
            end
            tick();
        end
        idle();
        repeat (4) tick();

        idle();
        cs = 2'b11; wr = 2'b11; addr[0] = 6'd3; addr[1] = 6'd4;
        wd[0] = 16'h1111; wd[1] = 16'h2222; be[0] = 2'b11; be[1] = 2'b11;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wait_clear(n);
        chk("clear_req_cycles", n, DEPTH);
        rd_word(0, 6'd3, d, lat, perr);
        chk("clear_req_word3", d, 16'h0);
        rd_word(1, 6'd4, d, lat, perr);
        chk("clear_req_word4", d, 16'h0);

        for (int a = 0; a < DEPTH; a++) wr_word(a % 2, a[AW-1:0], 16'hA5A5 ^ 16'(a), 2'b11);
        do_reset();
        repeat (9) @(posedge clk);
        do_reset();
        wait_clear(n);
        chk("clear_restart_cycles", n, DEPTH);
        for (int a = 0; a < DEPTH; a++) begin
            rd_word(1 - a % 2, a[AW-1:0], d, lat, perr);
            chk("restart_cleared_word", d, 16'h0);
        end

`ifdef LPC_SINK_RAM_PARITY_EN
        wr_word(0, 6'h30, 16'h1234, 2'b11);
        dut.u_core.mem[6'h30][8] = ~dut.u_core.mem[6'h30][8];
        rd_word(0, 6'h30, d, lat, perr);
        chk("parity_err_flipped", perr, 1'b1);
        rd_word(0, 6'h31, d, lat, perr);
        chk("parity_err_clean", perr, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
